core_sequencer: RTL and testbench

// Multi-cycle control FSM for the non-pipelined RV32I core. Sequences each instruction

---
 rtl/core_sequencer.sv | 171 +++++++++++++++++
 tb/tb_core_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM for the non-pipelined RV32I core. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> WB. The block owns the PC and the
// instruction register. It drives the imem/dmem request handshakes and the
// regfile write strobe, and it picks the next PC.
//
// Handshake: a request (imem_req / dmem_req) stays high with stable address
// until the matching ready is sampled high on a rising edge. That edge
// completes the transfer. The request may then drop or start a new transfer.
//
// Ports
//   clk           core clock, rising edge
//   reset         asynchronous, active-low reset
//   imem_req      fetch request (high in FETCH)
//   imem_addr     fetch address, equals pc
//   imem_ready    fetch data valid this cycle
//   imem_rdata    fetched instruction word
//   instr         instruction register
//   pc            current instruction address
//   target_addr   jump/branch target, sampled in WB
//   branch_taken  branch condition, sampled in WB
//   dmem_req      data request (high in MEM)
//   dmem_we       1 = store, 0 = load, valid with dmem_req
//   dmem_ready    data access complete this cycle
//   rf_we         register-file write strobe
//   retired       one-cycle pulse per completed instruction
//   fault         sticky error flag (FAULT state)
//   state         FSM state for debug
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic [31:0] target_addr,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        retired,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] TMO_LIMIT = 32'(MEM_TIMEOUT);

  state_t      st;
  logic [31:0] tmo_cnt;

  // Instruction class decode. instr is stable from DECODE through WB,
  // so these signals are decoded from the register rather than stored.
  logic [4:0] opcode;
  logic is_r, is_i, is_s, is_b, is_u, is_j;
  logic is_load, is_jalr, legal;

  assign opcode = instr[6:2];

  always_comb begin
    is_r = 1'b0;
    is_i = 1'b0;
    is_s = 1'b0;
    is_b = 1'b0;
    is_u = 1'b0;
    is_j = 1'b0;
    case (opcode)
      5'b01011, 5'b01100, 5'b01110, 5'b10100:          is_r = 1'b1;
      5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11001: is_i = 1'b1;
      5'b01000, 5'b01001:                               is_s = 1'b1;
      5'b11000:                                         is_b = 1'b1;
      5'b00101, 5'b01101:                               is_u = 1'b1;
      5'b11011:                                         is_j = 1'b1;
      default: ;
    endcase
  end

  assign is_load = (opcode == 5'b00000);
  assign is_jalr = (opcode == 5'b11001);
  assign legal   = (instr[1:0] == 2'b11) && (is_r | is_i | is_s | is_b | is_u | is_j);

  logic        redirect;
  logic        wb_misaligned;
  logic [31:0] pc_plus4;
  logic        timeout_hit;

  assign redirect      = is_j | is_jalr | (is_b & branch_taken);
  assign wb_misaligned = redirect && (target_addr[1:0] != 2'b00);
  assign pc_plus4      = pc + 32'd4;
  // This is the last allowed stall cycle. A limit of 0 disables the timeout.
  assign timeout_hit   = (TMO_LIMIT != 32'd0) && ((tmo_cnt + 32'd1) == TMO_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_FETCH;
      pc      <= RESET_PC;
      instr   <= NOP;
      tmo_cnt <= 32'd0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (imem_ready) begin
            instr   <= imem_rdata;
            tmo_cnt <= 32'd0;
            st      <= ST_DECODE;
          end else if (timeout_hit) begin
            tmo_cnt <= 32'd0;
            st      <= ST_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_DECODE: st <= legal ? ST_EXEC : ST_FAULT;
        ST_EXEC:   st <= (is_load || is_s) ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (dmem_ready) begin
            tmo_cnt <= 32'd0;
            if (is_s) begin
              // A store has no writeback, so it retires here.
              pc <= pc_plus4;
              st <= ST_FETCH;
            end else begin
              st <= ST_WB;
            end
          end else if (timeout_hit) begin
            tmo_cnt <= 32'd0;
            st      <= ST_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_WB: begin
          if (wb_misaligned) begin
            st <= ST_FAULT;
          end else begin
            pc <= redirect ? target_addr : pc_plus4;
            st <= ST_FETCH;
          end
        end
        ST_FAULT: st <= ST_FAULT;
        default:  st <= ST_FAULT;
      endcase
    end
  end

  assign imem_req  = (st == ST_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (st == ST_MEM);
  assign dmem_we   = (st == ST_MEM) && is_s;
  assign rf_we     = (st == ST_WB) && !is_b && !wb_misaligned;
  assign retired   = ((st == ST_WB) && !wb_misaligned) ||
                     ((st == ST_MEM) && is_s && dmem_ready);
  assign fault     = (st == ST_FAULT);
  assign state     = st;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          MEM_TIMEOUT = 8;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  localparam logic [31:0] W_ADDI = 32'h0010_0093;
  localparam logic [31:0] W_LW   = 32'h0000_2083;
  localparam logic [31:0] W_SW   = 32'h0010_2023;
  localparam logic [31:0] W_JAL  = 32'h0000_006F;
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] target_addr;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_we;
  logic        retired;
  logic        fault;
  logic [2:0]  state;

  core_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .target_addr(target_addr), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .retired(retired), .fault(fault), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural model state: where the program counter and instruction
  // register should be, tracked per instruction.
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Instruction class from the opcode table: 0 illegal, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
  function automatic int classify(input logic [31:0] w);
    if (w[1:0] != 2'b11) return 0;
    case (w[6:2])
      5'b01011, 5'b01100, 5'b01110, 5'b10100:          return 1;
      5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11001: return 2;
      5'b01000, 5'b01001:                               return 3;
      5'b11000:                                         return 4;
      5'b00101, 5'b01101:                               return 5;
      5'b11011:                                         return 6;
      default:                                          return 0;
    endcase
  endfunction

  // One clock cycle: check every output at the falling edge against the
  // expected state, then advance to just after the next rising edge.
  task automatic cyc(input logic [2:0] s, input logic exp_rf, input logic exp_ret, input logic exp_we);
    @(negedge clk);
    chk("state", {29'd0, state}, {29'd0, s});
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk1("imem_req", imem_req, s == 3'd0);
    chk1("dmem_req", dmem_req, s == 3'd3);
    chk1("rf_we", rf_we, exp_rf);
    chk1("retired", retired, exp_ret);
    chk1("fault", fault, s == 3'd5);
    if (s == 3'd3) chk1("dmem_we", dmem_we, exp_we);
    @(posedge clk);
    #1;
  endtask

  // FAULT must ignore both ready inputs and freeze pc/instr.
  task automatic fault_cycles(input int n);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc(3'd5, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, NOP);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_rf_we", rf_we, 1'b0);
    chk1("rst_retired", retired, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_pc = RESET_PC;
    m_instr = NOP;
  endtask

  // Run one instruction end to end. fw and mw are the stall cycles before
  // imem_ready / dmem_ready rise. faulted reports that the core is in FAULT.
  task automatic run_instr(input logic [31:0] word, input int fw, input int mw,
                           input logic [31:0] tgt, input logic tk, output bit faulted);
    int   c;
    logic is_mem;
    logic redirect;
    c = classify(word);
    faulted = 1'b0;
    target_addr = tgt;
    branch_taken = tk;
    imem_rdata = word;
    dmem_ready = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < fw && i < MEM_TIMEOUT; i++) cyc(3'd0, 1'b0, 1'b0, 1'b0);
    if (fw >= MEM_TIMEOUT) begin
      fault_cycles(3);
      faulted = 1'b1;
      return;
    end
    imem_ready = 1'b1;
    cyc(3'd0, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    m_instr = word;
    cyc(3'd1, 1'b0, 1'b0, 1'b0);
    if (c == 0) begin
      fault_cycles(3);
      faulted = 1'b1;
      return;
    end
    cyc(3'd2, 1'b0, 1'b0, 1'b0);
    is_mem = (c == 3) || (c == 2 && word[6:2] == 5'b00000);
    if (is_mem) begin
      for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) cyc(3'd3, 1'b0, 1'b0, c == 3);
      if (mw >= MEM_TIMEOUT) begin
        fault_cycles(3);
        faulted = 1'b1;
        return;
      end
      dmem_ready = 1'b1;
      if (c == 3) begin
        cyc(3'd3, 1'b0, 1'b1, 1'b1);
        dmem_ready = 1'b0;
        m_pc = m_pc + 32'd4;
        return;
      end
      cyc(3'd3, 1'b0, 1'b0, 1'b0);
      dmem_ready = 1'b0;
    end
    redirect = (c == 6) || (c == 2 && word[6:2] == 5'b11001) || (c == 4 && tk);
    if (redirect && tgt[1:0] != 2'b00) begin
      cyc(3'd4, 1'b0, 1'b0, 1'b0);
      fault_cycles(3);
      faulted = 1'b1;
      return;
    end
    cyc(3'd4, c != 4, 1'b1, 1'b0);
    m_pc = redirect ? tgt : m_pc + 32'd4;
  endtask

  logic [4:0] legal_ops [15] = '{5'b01011, 5'b01100, 5'b01110, 5'b10100,
                                 5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11001,
                                 5'b01000, 5'b01001, 5'b11000, 5'b00101, 5'b01101, 5'b11011};

  initial begin
    bit          f;
    logic [31:0] w;
    logic [31:0] t;
    int          fw;
    int          mw;

    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    dmem_ready = 1'b0;
    target_addr = 32'd0;
    branch_taken = 1'b0;
    m_pc = RESET_PC;
    m_instr = NOP;
    #2;

    // Reset state, then two back-to-back ADDIs with memories ready at once.
    do_reset();
    run_instr(W_ADDI, 0, 0, 32'd0, 1'b0, f);
    run_instr(W_ADDI, 0, 0, 32'd0, 1'b0, f);
    chk("addi_pc", m_pc, 32'd8);

    // Load with three stall cycles, store, JAL, JALR, BEQ not taken and taken.
    run_instr(W_LW, 1, 3, 32'd0, 1'b0, f);
    run_instr(W_SW, 0, 2, 32'd0, 1'b0, f);
    run_instr(W_JAL, 0, 0, 32'h40, 1'b0, f);
    run_instr(32'h0000_8067, 0, 0, 32'h100, 1'b0, f);
    run_instr(W_BEQ, 0, 0, 32'h200, 1'b0, f);
    run_instr(W_BEQ, 0, 0, 32'h200, 1'b1, f);

    // The pc wraps modulo 2^32 without a fault.
    run_instr(W_JAL, 0, 0, 32'hFFFF_FFFC, 1'b0, f);
    run_instr(W_ADDI, 0, 0, 32'd0, 1'b0, f);
    chk("wrap_pc", m_pc, 32'd0);

    // Illegal word, fetch timeout, misaligned redirect, data timeout.
    run_instr(32'hFFFF_FFFF, 0, 0, 32'd0, 1'b0, f);
    do_reset();
    run_instr(W_ADDI, 8, 0, 32'd0, 1'b0, f);
    do_reset();
    run_instr(W_JAL, 0, 0, 32'h42, 1'b0, f);
    do_reset();
    run_instr(W_LW, 0, 8, 32'd0, 1'b0, f);
    do_reset();

    // Reset in the middle of a stalled load aborts it.
    run_instr(W_ADDI, 0, 0, 32'd0, 1'b0, f);
    imem_rdata = W_LW;
    imem_ready = 1'b1;
    cyc(3'd0, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    m_instr = W_LW;
    cyc(3'd1, 1'b0, 1'b0, 1'b0);
    cyc(3'd2, 1'b0, 1'b0, 1'b0);
    cyc(3'd3, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk1("abort_dmem_req", dmem_req, 1'b0);
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_pc", pc, RESET_PC);
    chk1("abort_retired", retired, 1'b0);
    chk1("abort_rf_we", rf_we, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_pc = RESET_PC;
    m_instr = NOP;
    cyc(3'd0, 1'b0, 1'b0, 1'b0);

    // Random instruction stream against the model.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        w = $urandom;
      end else begin
        w = $urandom;
        w[6:2] = legal_ops[$urandom_range(0, 14)];
        w[1:0] = 2'b11;
      end
      fw = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
      mw = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT + 1 : $urandom_range(0, 4);
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      run_instr(w, fw, mw, t, 1'($urandom_range(0, 1)), f);
      if (f) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
